alu_param: RTL and testbench

Parametrised multi-cycle integer ALU with a WIDTH-bit word bus. It performs signed add and subtract, signed radix-4 Booth multiplication and unsigned 2W/W non-restoring division. Operands are streamed in over `inbus` and results are streamed out over a tri-stated `outbus`, all under a BEGIN/END handshake. It is the WIDTH-generic successor of the 8-bit sequential ALU, and adds busy, overflow and divide-by-zero reporting.

---
 rtl/alu_param_pkg.sv | 44 ++++
 rtl/alu_param_fsm.sv | 94 +++++++++
 rtl/alu_param.sv | 178 +++++++++++++++++
 tb/tb_alu_param.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_param_pkg.sv
// Shared definitions for alu_param: op codes, FSM states, Booth digits, operand counts.
package alu_param_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ADD,
    ST_MUL_STEP,
    ST_DIV_STEP,
    ST_DIV_CORR,
    ST_OUT_HI,
    ST_OUT_LO
  } state_t;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_t;

  // Radix-4 recoding of {Q[1], Q[0], Q[-1]}
  function automatic booth_t booth_recode(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return BD_POS1;
      3'b011:         return BD_POS2;
      3'b100:         return BD_NEG2;
      3'b101, 3'b110: return BD_NEG1;
      default:        return BD_ZERO;
    endcase
  endfunction

  function automatic logic [1:0] load_words(input logic [1:0] op);
    return (op == OP_DIV) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/alu_param_fsm.sv
// Control FSM for alu_param: state register, load/step counters and op latch.
// Macro ALU_PARAM_DIV_EN enables the DIV_STEP/DIV_CORR sequencing.
module alu_param_fsm
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_begin,
  input  logic [1:0] i_op_code,
  input  logic       i_div_flag,
  output state_t     o_state,
  output logic [1:0] o_op,
  output logic [1:0] o_load_idx,
  output logic       o_accept
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
`ifdef ALU_PARAM_DIV_EN
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
`endif

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_op, w_op_nxt;
  logic [1:0]    r_load, w_load_nxt;
  logic [CW-1:0] r_step, w_step_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_load  <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_load  <= w_load_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_load_nxt  = r_load;
    w_step_nxt  = r_step;
    case (r_state)
      ST_IDLE: begin
        if (i_begin) begin
          w_state_nxt = ST_LOAD;
          w_op_nxt    = i_op_code;
          w_load_nxt  = '0;
          w_step_nxt  = '0;
        end
      end
      ST_LOAD: begin
        if (r_load == load_words(r_op) - 2'd1) begin
          case (r_op)
            OP_MUL:  w_state_nxt = ST_MUL_STEP;
            OP_DIV:  w_state_nxt = ST_CHECK;
            default: w_state_nxt = ST_ADD;
          endcase
        end else begin
          w_load_nxt = r_load + 2'd1;
        end
      end
      ST_ADD: w_state_nxt = ST_OUT_LO;
      ST_MUL_STEP: begin
        if (r_step == MUL_LAST) w_state_nxt = ST_OUT_HI;
        else                    w_step_nxt  = r_step + 1'b1;
      end
      // Without the divider the flag is tied high, so CHECK always skips to output
      ST_CHECK: w_state_nxt = i_div_flag ? ST_OUT_HI : ST_DIV_STEP;
`ifdef ALU_PARAM_DIV_EN
      ST_DIV_STEP: begin
        if (r_step == DIV_LAST) w_state_nxt = ST_DIV_CORR;
        else                    w_step_nxt  = r_step + 1'b1;
      end
      ST_DIV_CORR: w_state_nxt = ST_OUT_HI;
`endif
      ST_OUT_HI: w_state_nxt = ST_OUT_LO;
      ST_OUT_LO: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_state    = r_state;
  assign o_op       = r_op;
  assign o_load_idx = r_load;
  assign o_accept   = (r_state == ST_IDLE) && i_begin;

endmodule

// File: rtl/alu_param.sv
// Multi-cycle add/sub, radix-4 Booth multiply and 2W/W non-restoring divide.
// Macro ALU_PARAM_DIV_EN compiles in the divider; otherwise op 11 reports overflow.
module alu_param
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BEGIN,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid,
  output logic             END,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int AW = WIDTH + 2;

  state_t           w_state;
  logic [1:0]       w_op;
  logic [1:0]       w_load_idx;
  logic             w_accept;
  logic             w_div_flag;

  logic [AW-1:0]    r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_qm1;
  logic             r_ovf;
  logic             r_dbz;

  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic [AW-1:0]    w_m_ext;
  logic [AW-1:0]    w_digit;
  logic [AW-1:0]    w_acc;
  logic [WIDTH-1:0] w_out;

  alu_param_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .i_begin    (BEGIN),
    .i_op_code  (op_code),
    .i_div_flag (w_div_flag),
    .o_state    (w_state),
    .o_op       (w_op),
    .o_load_idx (w_load_idx),
    .o_accept   (w_accept)
  );

  // X lives in A[W-1:0] and Y in M for add/sub
  assign w_sum     = (w_op == OP_SUB) ? (r_a[WIDTH-1:0] - r_m) : (r_a[WIDTH-1:0] + r_m);
  assign w_add_ovf = (w_sum[WIDTH-1] != r_a[WIDTH-1]) &&
                     ((w_op == OP_SUB) ? (r_a[WIDTH-1] != r_m[WIDTH-1])
                                       : (r_a[WIDTH-1] == r_m[WIDTH-1]));

  assign w_m_ext = {{2{r_m[WIDTH-1]}}, r_m};

  always_comb begin
    w_digit = '0;
    case (booth_recode({r_q[1:0], r_qm1}))
      BD_POS1: w_digit = w_m_ext;
      BD_POS2: w_digit = w_m_ext << 1;
      BD_NEG1: w_digit = -w_m_ext;
      BD_NEG2: w_digit = -(w_m_ext << 1);
      default: w_digit = '0;
    endcase
  end

  assign w_acc = r_a + w_digit;

`ifdef ALU_PARAM_DIV_EN
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_rem_nxt;

  // W+1-bit remainder arithmetic is modular; the true result always fits
  assign w_rem_sh   = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_rem_nxt  = r_a[WIDTH] ? (w_rem_sh + {1'b0, r_m}) : (w_rem_sh - {1'b0, r_m});
  assign w_div_flag = (r_m == '0) || (r_a[WIDTH-1:0] >= r_m);
`else
  assign w_div_flag = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_qm1 <= 1'b0;
      r_ovf <= 1'b0;
      r_dbz <= 1'b0;
    end else begin
      case (w_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ovf <= 1'b0;
            r_dbz <= 1'b0;
          end
        end
        ST_LOAD: begin
          case (w_op)
            OP_MUL: begin
              if (w_load_idx == 2'd0) begin
                r_m <= inbus;
              end else begin
                r_q   <= inbus;
                r_a   <= '0;
                r_qm1 <= 1'b0;
              end
            end
            OP_DIV: begin
              case (w_load_idx)
                2'd0:    r_a <= {2'b00, inbus};
                2'd1:    r_q <= inbus;
                default: r_m <= inbus;
              endcase
            end
            default: begin
              if (w_load_idx == 2'd0) r_a <= {2'b00, inbus};
              else                    r_m <= inbus;
            end
          endcase
        end
        ST_ADD: begin
          r_q   <= w_sum;
          r_ovf <= w_add_ovf;
        end
        ST_MUL_STEP: begin
          r_a   <= {{2{w_acc[AW-1]}}, w_acc[AW-1:2]};
          r_q   <= {w_acc[1:0], r_q[WIDTH-1:2]};
          r_qm1 <= r_q[1];
        end
`ifdef ALU_PARAM_DIV_EN
        ST_CHECK: begin
          if (r_m == '0)                    r_dbz <= 1'b1;
          else if (r_a[WIDTH-1:0] >= r_m)   r_ovf <= 1'b1;
          if (w_div_flag) r_q <= '1;
        end
        ST_DIV_STEP: begin
          r_a <= {w_rem_nxt[WIDTH], w_rem_nxt};
          r_q <= {r_q[WIDTH-2:0], ~w_rem_nxt[WIDTH]};
        end
        ST_DIV_CORR: begin
          if (r_a[WIDTH]) r_a <= {1'b0, r_a[WIDTH:0] + {1'b0, r_m}};
        end
`else
        ST_CHECK: begin
          r_a   <= '0;
          r_q   <= '0;
          r_ovf <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_out = r_q;
    case (w_op)
      OP_MUL:  w_out = (w_state == ST_OUT_HI) ? r_a[WIDTH-1:0] : r_q;
      OP_DIV:  w_out = (w_state == ST_OUT_HI) ? r_q : r_a[WIDTH-1:0];
      default: w_out = r_q;
    endcase
  end

  assign out_valid   = (w_state == ST_OUT_HI) || (w_state == ST_OUT_LO);
  assign outbus      = out_valid ? w_out : 'z;
  assign END         = (w_state == ST_OUT_LO);
  assign busy        = (w_state != ST_IDLE);
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param (WIDTH=8) against an arithmetic reference model.
module tb_alu_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         BEGIN;
  logic [1:0]   op_code;
  logic [W-1:0] inbus;
  logic [W-1:0] outbus;
  logic         out_valid, END, busy, overflow, div_by_zero;

  int n_checks = 0;
  int n_bad    = 0;

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         nw;
    int         endc;
    logic       ovf;
    logic       dbz;
  } res_t;

  always #5 clk = ~clk;

  alu_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .BEGIN       (BEGIN),
    .op_code     (op_code),
    .inbus       (inbus),
    .outbus      (outbus),
    .out_valid   (out_valid),
    .END         (END),
    .busy        (busy),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  function automatic res_t model(input logic [1:0] op, input logic [7:0] a, b, c);
    res_t r;
    int   sa, sb, s, p, dvd, qt, rm;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r.w0 = '0; r.w1 = '0; r.ovf = 1'b0; r.dbz = 1'b0; r.nw = 2;
    case (op)
      2'b00, 2'b01: begin
        s = (op == 2'b00) ? sa + sb : sa - sb;
        r.w0 = s[7:0]; r.ovf = (s > 127) || (s < -128); r.nw = 1; r.endc = 4;
      end
      2'b10: begin
        p = sa * sb;
        r.w0 = p[15:8]; r.w1 = p[7:0]; r.endc = 8;
      end
      default: begin
`ifdef ALU_PARAM_DIV_EN
        if (c == 8'h00 || a >= c) begin
          r.dbz = (c == 8'h00); r.ovf = (c != 8'h00);
          r.w0 = 8'hFF; r.w1 = a; r.endc = 6;
        end else begin
          dvd = int'(a) * 256 + int'(b);
          qt = dvd / int'(c); rm = dvd % int'(c);
          r.w0 = qt[7:0]; r.w1 = rm[7:0]; r.endc = 15;
        end
`else
        r.ovf = 1'b1; r.endc = 6;
`endif
      end
    endcase
    return r;
  endfunction

  // Drives one transaction from its BEGIN cycle and records what the DUT produced
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, b, c, input int pulse_at,
                        output res_t o, output bit busy_ok);
    int cyc;
    o.w0 = '0; o.w1 = '0; o.nw = 0; o.endc = -1; o.ovf = 1'b0; o.dbz = 1'b0;
    busy_ok = 1'b1;
    @(negedge clk); BEGIN = 1'b1; op_code = op; cyc = 0;
    @(negedge clk); cyc = 1; BEGIN = 1'b0; inbus = a; busy_ok &= busy;
    @(negedge clk); cyc = 2; inbus = b; busy_ok &= busy;
    if (op == 2'b11) begin
      @(negedge clk); cyc = 3; inbus = c; busy_ok &= busy;
    end
    while (o.endc < 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      inbus = 8'($urandom);
      busy_ok &= busy;
      if (out_valid) begin
        if (o.nw == 0) o.w0 = outbus; else o.w1 = outbus;
        o.nw++;
      end
      if (END) begin
        o.endc = cyc; o.ovf = overflow; o.dbz = div_by_zero;
      end
      BEGIN = (cyc == pulse_at);
      if (cyc == pulse_at) op_code = 2'b00;
    end
    BEGIN = 1'b0;
  endtask

  task automatic test_reset();
    res_t o; bit bk;
    reset = 1'b0; BEGIN = 1'b0; op_code = 2'b00; inbus = '0;
    #12;
    n_checks++;
    if ({busy, out_valid, END, overflow, div_by_zero} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_init: busy/valid/end/ovf/dbz got %b want 00000",
               {busy, out_valid, END, overflow, div_by_zero});
    end
    @(negedge clk); reset = 1'b1;
    run_op(2'b00, 8'h7F, 8'h01, 8'h00, -1, o, bk);
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flag_hold: ovf=%b busy=%b want ovf=1 busy=0", overflow, busy);
    end
    reset = 1'b0; #1;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_clears_ovf: got %b want 0", overflow);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_addsub();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] op; logic [7:0] a, b; res_t e, o; bit bk;
      case (i)
        0: begin op = 2'b00; a = 8'h7F; b = 8'h01; end
        1: begin op = 2'b01; a = 8'h05; b = 8'h09; end
        2: begin op = 2'b01; a = 8'h80; b = 8'h01; end
        3: begin op = 2'b00; a = 8'h80; b = 8'hFF; end
        default: begin op = 2'($urandom_range(0, 1)); a = 8'($urandom); b = 8'($urandom); end
      endcase
      e = model(op, a, b, 8'h00);
      run_op(op, a, b, 8'h00, -1, o, bk);
      n_checks++;
      if (o.w0 !== e.w0 || o.nw !== e.nw) begin
        n_bad++;
        $display("FAIL addsub[%0d] op=%0d %h,%h: got %h (%0d words) want %h (%0d words)",
                 i, op, a, b, o.w0, o.nw, e.w0, e.nw);
      end
      n_checks++;
      if ({o.ovf, o.dbz} !== {e.ovf, e.dbz} || o.endc !== e.endc || !bk) begin
        n_bad++;
        $display("FAIL addsub_ctl[%0d]: ovf/dbz=%b%b end=%0d busy_ok=%0d want %b%b end=%0d",
                 i, o.ovf, o.dbz, o.endc, bk, e.ovf, e.dbz, e.endc);
      end
    end
  endtask

  task automatic test_mul();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b; res_t e, o; bit bk;
      case (i)
        0: begin a = 8'h80; b = 8'h80; end
        1: begin a = 8'h07; b = 8'hFD; end
        2: begin a = 8'h7F; b = 8'h80; end
        3: begin a = 8'hFF; b = 8'h7F; end
        default: begin a = 8'($urandom); b = 8'($urandom); end
      endcase
      e = model(2'b10, a, b, 8'h00);
      run_op(2'b10, a, b, 8'h00, -1, o, bk);
      n_checks++;
      if (o.w0 !== e.w0 || o.w1 !== e.w1 || o.nw !== e.nw) begin
        n_bad++;
        $display("FAIL mul[%0d] %h*%h: got %h,%h (%0d words) want %h,%h (%0d words)",
                 i, a, b, o.w0, o.w1, o.nw, e.w0, e.w1, e.nw);
      end
      n_checks++;
      if ({o.ovf, o.dbz} !== 2'b00 || o.endc !== e.endc || !bk) begin
        n_bad++;
        $display("FAIL mul_ctl[%0d]: ovf/dbz=%b%b end=%0d busy_ok=%0d want 00 end=%0d",
                 i, o.ovf, o.dbz, o.endc, bk, e.endc);
      end
    end
  endtask

  task automatic test_div();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a, q, m; res_t e, o; bit bk;
      case (i)
        0: begin a = 8'h00; q = 8'h64; m = 8'h07; end
        1: begin a = 8'h12; q = 8'h34; m = 8'h00; end
        2: begin a = 8'h09; q = 8'h00; m = 8'h05; end
        3: begin a = 8'h05; q = 8'hAA; m = 8'h05; end
        4: begin a = 8'h04; q = 8'hFF; m = 8'h05; end
        5: begin a = 8'hFE; q = 8'hFF; m = 8'hFF; end
        default: begin
          m = 8'($urandom_range(0, 255));
          q = 8'($urandom);
          if (i % 4 == 0 || m == 8'h00) a = 8'($urandom);
          else a = 8'($urandom_range(0, int'(m) - 1));
        end
      endcase
      e = model(2'b11, a, q, m);
      run_op(2'b11, a, q, m, -1, o, bk);
      n_checks++;
      if (o.w0 !== e.w0 || o.w1 !== e.w1 || o.nw !== e.nw) begin
        n_bad++;
        $display("FAIL div[%0d] %h%h/%h: got %h,%h (%0d words) want %h,%h (%0d words)",
                 i, a, q, m, o.w0, o.w1, o.nw, e.w0, e.w1, e.nw);
      end
      n_checks++;
      if ({o.ovf, o.dbz} !== {e.ovf, e.dbz} || o.endc !== e.endc || !bk) begin
        n_bad++;
        $display("FAIL div_ctl[%0d]: ovf/dbz=%b%b end=%0d busy_ok=%0d want %b%b end=%0d",
                 i, o.ovf, o.dbz, o.endc, bk, e.ovf, e.dbz, e.endc);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e, o; bit bk;
    logic [7:0] a, b;
    e = model(2'b10, 8'h80, 8'h80, 8'h00);
    run_op(2'b10, 8'h80, 8'h80, 8'h00, 4, o, bk);
    n_checks++;
    if (o.w0 !== e.w0 || o.w1 !== e.w1 || o.endc !== e.endc || !bk) begin
      n_bad++;
      $display("FAIL begin_ignored: got %h,%h end=%0d busy_ok=%0d want %h,%h end=%0d",
               o.w0, o.w1, o.endc, bk, e.w0, e.w1, e.endc);
    end
    a = 8'($urandom); b = 8'($urandom);
    e = model(2'b01, a, b, 8'h00);
    run_op(2'b01, a, b, 8'h00, -1, o, bk);
    n_checks++;
    if (o.w0 !== e.w0 || o.ovf !== e.ovf || o.endc !== e.endc || !bk) begin
      n_bad++;
      $display("FAIL back_to_back: got %h ovf=%b end=%0d want %h ovf=%b end=%0d",
               o.w0, o.ovf, o.endc, e.w0, e.ovf, e.endc);
    end
  endtask

  task automatic test_reset_midop();
    res_t e, o; bit bk;
    @(negedge clk); BEGIN = 1'b1; op_code = 2'b10;
    @(negedge clk); BEGIN = 1'b0; inbus = 8'h35;
    @(negedge clk); inbus = 8'hC4;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midop_busy: busy=%b valid=%b want 1,0", busy, out_valid);
    end
    reset = 1'b0; #1;
    n_checks++;
    if ({busy, out_valid, END, overflow, div_by_zero} !== 5'b0) begin
      n_bad++;
      $display("FAIL midop_reset: busy/valid/end/ovf/dbz got %b want 00000",
               {busy, out_valid, END, overflow, div_by_zero});
    end
    @(negedge clk); reset = 1'b1;
    e = model(2'b00, 8'h7F, 8'h7F, 8'h00);
    run_op(2'b00, 8'h7F, 8'h7F, 8'h00, -1, o, bk);
    n_checks++;
    if (o.w0 !== e.w0 || o.ovf !== e.ovf || o.endc !== e.endc || !bk) begin
      n_bad++;
      $display("FAIL after_reset_add: got %h ovf=%b end=%0d want %h ovf=%b end=%0d",
               o.w0, o.ovf, o.endc, e.w0, e.ovf, e.endc);
    end
    e = model(2'b10, 8'h35, 8'hC4, 8'h00);
    run_op(2'b10, 8'h35, 8'hC4, 8'h00, -1, o, bk);
    n_checks++;
    if (o.w0 !== e.w0 || o.w1 !== e.w1 || o.endc !== e.endc) begin
      n_bad++;
      $display("FAIL after_reset_mul: got %h,%h end=%0d want %h,%h end=%0d",
               o.w0, o.w1, o.endc, e.w0, e.w1, e.endc);
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
